// File: rtl/awg_pkg.sv
// Shared definitions for the AWG sweep sequencer: register map, control bits,
// FSM states and the amplitude floor.
package awg_pkg;

  localparam logic [2:0] REG_FSTART = 3'd0;
  localparam logic [2:0] REG_FSTOP  = 3'd1;
  localparam logic [2:0] REG_FSTEP  = 3'd2;
  localparam logic [2:0] REG_DWELL  = 3'd3;
  localparam logic [2:0] REG_AMP    = 3'd4;
  localparam logic [2:0] REG_PHASE  = 3'd5;
  localparam logic [2:0] REG_CTRL   = 3'd6;

  localparam int unsigned CTRL_START     = 0;
  localparam int unsigned CTRL_LOOP      = 1;
  localparam int unsigned CTRL_ABORT     = 2;
  localparam int unsigned CTRL_EN_MANUAL = 3;

  localparam logic [2:0] AMP_MIN = 3'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    STEP  = 2'd2
  } state_t;

endpackage

// File: rtl/awg_sweep_ctrl_dwell_timer.sv
// Dwell timer: prescaler by DWELL_DIV feeding a tick counter; expire is high on
// the last clock of a (dwell+1)*DWELL_DIV window that starts when clr drops.
module dwell_timer #(
  parameter int DWELL_DIV = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [11:0] dwell,
  output logic        expire
);

  localparam int PW = (DWELL_DIV > 1) ? $clog2(DWELL_DIV) : 1;

  logic [PW-1:0] pre;
  logic [11:0]   ticks;
  logic          pre_wrap;

  assign pre_wrap = (pre == PW'(DWELL_DIV - 1));
  assign expire   = !clr && pre_wrap && (ticks == dwell);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre   <= '0;
      ticks <= '0;
    end else if (clr) begin
      pre   <= '0;
      ticks <= '0;
    end else if (pre_wrap) begin
      pre   <= '0;
      ticks <= ticks + 12'd1;
    end else begin
      pre <= pre + PW'(1);
    end
  end

endmodule

// File: rtl/awg_sweep_ctrl.sv
// Register-programmed linear frequency sweep sequencer for the sine generator:
// register file, sweep FSM and registered generator controls.
module awg_sweep_ctrl
  import awg_pkg::*;
#(
  parameter int FREQ_W    = 12,
  parameter int DWELL_DIV = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [2:0]        wr_addr,
  input  logic [11:0]       wr_data,
  output logic              en,
  output logic [FREQ_W-1:0] freq,
  output logic [2:0]        amp,
  output logic [7:0]        phase,
  output logic              busy,
  output logic              done,
  output logic              wrap
);

  logic [11:0] r_fstart, r_fstop, r_fstep, r_dwell;
  logic        r_loop, r_en_manual;

  logic [FREQ_W-1:0] w_start, w_stop, w_step;
  logic [11:0]       w_dwell;

  state_t            state, state_n;
  logic [FREQ_W-1:0] freq_n;
  logic              en_n, done_n, wrap_n, load;
  logic [FREQ_W:0]   next_f, stop_ext;
  logic              wr_ctrl, abort_cmd, start_cmd, expire;

  assign wr_ctrl   = wr_en && (wr_addr == REG_CTRL);
  assign abort_cmd = wr_ctrl && wr_data[CTRL_ABORT];
  assign start_cmd = wr_ctrl && wr_data[CTRL_START] && !wr_data[CTRL_ABORT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fstart    <= '0;
      r_fstop     <= '0;
      r_fstep     <= '0;
      r_dwell     <= '0;
      r_loop      <= 1'b0;
      r_en_manual <= 1'b0;
      amp         <= AMP_MIN;
      phase       <= '0;
    end else if (wr_en) begin
      case (wr_addr)
        REG_FSTART: r_fstart <= wr_data;
        REG_FSTOP:  r_fstop  <= wr_data;
        REG_FSTEP:  r_fstep  <= wr_data;
        REG_DWELL:  r_dwell  <= wr_data;
        REG_AMP:    amp      <= (wr_data[2:0] == 3'd0) ? AMP_MIN : wr_data[2:0];
        REG_PHASE:  phase    <= wr_data[7:0];
        REG_CTRL: begin
          r_loop      <= wr_data[CTRL_LOOP];
          r_en_manual <= wr_data[CTRL_EN_MANUAL];
        end
        default: ;
      endcase
    end
  end

  dwell_timer #(
    .DWELL_DIV(DWELL_DIV)
  ) u_dwell_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (state != DWELL),
    .dwell  (w_dwell),
    .expire (expire)
  );

  assign next_f   = {1'b0, freq} + {1'b0, w_step};
  assign stop_ext = {1'b0, w_stop};

  always_comb begin
    state_n = state;
    freq_n  = freq;
    en_n    = en;
    done_n  = 1'b0;
    wrap_n  = 1'b0;
    load    = 1'b0;
    if (abort_cmd) begin
      state_n = IDLE;
      freq_n  = FREQ_W'(r_fstart);
      en_n    = wr_data[CTRL_EN_MANUAL];
    end else begin
      case (state)
        IDLE: begin
          if (start_cmd) begin
            state_n = DWELL;
            freq_n  = FREQ_W'(r_fstart);
            en_n    = 1'b1;
            load    = 1'b1;
          end else if (wr_ctrl) begin
            // en tracks en_manual in IDLE, but a finished sweep leaves it at 1
            // until the next control write.
            en_n = wr_data[CTRL_EN_MANUAL];
          end
        end
        DWELL: begin
          if (expire) state_n = STEP;
        end
        STEP: begin
          if ((freq == w_stop) || (w_start > w_stop)) begin
            if (r_loop) begin
              state_n = DWELL;
              freq_n  = w_start;
              wrap_n  = 1'b1;
            end else begin
              state_n = IDLE;
              done_n  = 1'b1;
            end
          end else if (next_f > stop_ext) begin
            state_n = DWELL;
            freq_n  = w_stop;
          end else begin
            state_n = DWELL;
            freq_n  = next_f[FREQ_W-1:0];
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      freq    <= '0;
      en      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wrap    <= 1'b0;
      w_start <= '0;
      w_stop  <= '0;
      w_step  <= '0;
      w_dwell <= '0;
    end else begin
      state <= state_n;
      freq  <= freq_n;
      en    <= en_n;
      busy  <= (state_n != IDLE);
      done  <= done_n;
      wrap  <= wrap_n;
      if (load) begin
        w_start <= FREQ_W'(r_fstart);
        w_stop  <= FREQ_W'(r_fstop);
        w_step  <= FREQ_W'(r_fstep);
        w_dwell <= r_dwell;
      end
    end
  end

endmodule

// File: tb/tb_awg_sweep_ctrl.sv
// Self-checking bench for awg_sweep_ctrl with DWELL_DIV=4: directed scenarios
// plus randomized sweeps checked against a list-based sweep model.
module tb_awg_sweep_ctrl;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [11:0] wr_data = '0;
  logic        en, busy, done, wrap;
  logic [11:0] freq;
  logic [2:0]  amp;
  logic [7:0]  phase;
  logic [18:0] obs;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_amp = 3'd1;
  int cur_fs = 0;

  assign obs = {en, busy, done, wrap, amp, freq};

  awg_sweep_ctrl #(
    .FREQ_W    (12),
    .DWELL_DIV (DIV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .en      (en),
    .freq    (freq),
    .amp     (amp),
    .phase   (phase),
    .busy    (busy),
    .done    (done),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  // One register write; called and returns at a falling edge.
  task automatic wr(input logic [2:0] a, input logic [11:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    if (a == 3'd0) cur_fs = int'(d);
    if (a == 3'd4) exp_amp = (d[2:0] == 3'd0) ? 3'd1 : d[2:0];
  endtask

  // Sweep model: the list of frequencies visited by one pass.
  task automatic build_seq(input int fs, input int fe, input int st, output int q[$]);
    int v;
    q.delete();
    v = fs;
    q.push_back(v);
    if (fs <= fe)
      while (v != fe && q.size() < 64) begin
        v = (v + st > fe) ? fe : v + st;
        q.push_back(v);
      end
  endtask

  task automatic chk(input string name, input logic [18:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got {en,busy,done,wrap,amp,freq}=%h expected %h at %0t", name, obs, expv, $time);
    end
  endtask

  // Programs and starts a sweep, then checks every held cycle; optionally
  // injects one register write at sample index inj_at.
  task automatic run_sweep(input string name, input int fs, input int fe, input int st,
                           input int dw, input bit lp, input int nvals,
                           input int inj_at, input logic [2:0] ia, input logic [11:0] id);
    int q[$];
    int n, h, g, v, last;
    bit wexp;
    wr(3'd0, 12'(fs)); wr(3'd1, 12'(fe)); wr(3'd2, 12'(st)); wr(3'd3, 12'(dw));
    wr(3'd6, {10'd0, lp, 1'b1});
    build_seq(fs, fe, st, q);
    n = lp ? nvals : q.size();
    h = (dw + 1) * DIV + 1;
    g = 0;
    last = 0;
    for (int i = 0; i < n; i++) begin
      v = q[i % q.size()];
      last = v;
      for (int c = 0; c < h; c++) begin
        if (inj_at >= 0 && g == inj_at + 1) begin
          wr_en = 1'b0;
          if (ia == 3'd4) exp_amp = (id[2:0] == 3'd0) ? 3'd1 : id[2:0];
        end
        wexp = lp && (i > 0) && (c == 0) && (i % q.size() == 0);
        chk($sformatf("%s val%0d cyc%0d", name, i, c), {1'b1, 1'b1, 1'b0, wexp, exp_amp, 12'(v)});
        if (g == inj_at) begin
          wr_en = 1'b1; wr_addr = ia; wr_data = id;
        end
        g++;
        @(negedge clk);
      end
    end
    if (!lp) begin
      chk({name, " done"}, {1'b1, 1'b0, 1'b1, 1'b0, exp_amp, 12'(last)});
      @(negedge clk);
      chk({name, " after"}, {1'b1, 1'b0, 1'b0, 1'b0, exp_amp, 12'(last)});
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset defaults", {1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 12'd0});
    checks++;
    if (phase !== 8'd0) begin errors++; $display("FAIL reset phase: got %h expected 00", phase); end
    rst = 1'b0;
    @(negedge clk);
    wr(3'd0, 12'd100); wr(3'd1, 12'd130); wr(3'd2, 12'd10); wr(3'd3, 12'd1); wr(3'd4, 12'd6);
    wr(3'd6, 12'h001);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    exp_amp = 3'd1;
    cur_fs = 0;
    #1 chk("async reset mid-sweep", {1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 12'd0});
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    wr(3'd4, 12'd3);
    chk("write after reset", {1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 12'd0});
  endtask

  task automatic test_single_shot;
    run_sweep("single", 100, 130, 10, 1, 1'b0, 0, -1, 3'd0, 12'd0);
  endtask

  task automatic test_clamp;
    run_sweep("clamp", 100, 125, 10, 1, 1'b0, 0, -1, 3'd0, 12'd0);
    run_sweep("overflow", 4090, 4095, 10, 0, 1'b0, 0, -1, 3'd0, 12'd0);
  endtask

  task automatic test_amp;
    wr(3'd4, 12'd0);
    chk("amp zero guard", {en, busy, done, wrap, 3'd1, freq});
    wr(3'd4, 12'hFF7);
    chk("amp seven", {en, busy, done, wrap, 3'd7, freq});
    wr(3'd5, 12'h3A5);
    checks++;
    if (phase !== 8'hA5) begin errors++; $display("FAIL phase write: got %h expected a5", phase); end
    run_sweep("amp mid-sweep", 100, 130, 10, 1, 1'b0, 0, 3, 3'd4, 12'd5);
  endtask

  task automatic test_priority;
    wr(3'd6, 12'h005);
    for (int i = 0; i < 3; i++) begin
      chk("start|abort stays idle", {1'b0, 1'b0, 1'b0, 1'b0, exp_amp, 12'(cur_fs)});
      @(negedge clk);
    end
    run_sweep("start while busy", 100, 130, 10, 1, 1'b0, 0, 12, 3'd6, 12'h001);
    run_sweep("start>stop", 200, 100, 10, 1, 1'b0, 0, -1, 3'd0, 12'd0);
  endtask

  task automatic test_loop_abort;
    run_sweep("loop", 50, 60, 10, 1, 1'b1, 3, -1, 3'd0, 12'd0);
    wr(3'd6, 12'h004);
    for (int i = 0; i < 4; i++) begin
      chk("abort idle", {1'b0, 1'b0, 1'b0, 1'b0, exp_amp, 12'd50});
      @(negedge clk);
    end
  endtask

  task automatic test_random;
    int q[$];
    int fs, fe, st, dw;
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < 50; k++) begin
        fs = $urandom_range(0, 4095);
        fe = $urandom_range(0, 4095);
        st = $urandom_range(1, 4095);
        build_seq(fs, fe, st, q);
        if (q.size() <= 8) break;
        fe = fs + 3 * st;
        if (fe > 4095) fe = 4095;
      end
      dw = $urandom_range(0, 2);
      run_sweep($sformatf("random%0d", t), fs, fe, st, dw, 1'b0, 0, -1, 3'd0, 12'd0);
    end
  endtask

  initial begin
    test_reset;
    test_single_shot;
    test_clamp;
    test_amp;
    test_priority;
    test_loop_abort;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
